// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: segment bit positions, dark code and hex glyph table.
package seg_pkg;

  localparam logic [7:0] SEG_DARK = 8'h00;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Bit order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex7(input logic [3:0] value);
    return HEX7_TABLE[value];
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational 4-bit hex to 7-segment {g..a} decoder.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] value_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = hex7(value_i);
  end

endmodule

// File: rtl/led_seg_scanner_n.sv
// Multiplexed DIGITS-wide hex display scanner with PWM brightness and frame-coherent shadows.
// Optional per-digit blink is built only when SEG_BLINK_EN is defined.
module led_seg_scanner_n
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned CLK_FREQ = 1000000,
  parameter int unsigned SCAN_HZ  = 2000,
  parameter int unsigned BLINK_HZ = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blink,
  input  logic [2:0]            brightness,
  output logic [7:0]            seg_data,
  output logic [DIGITS-1:0]     seg_sel
);

  localparam int unsigned SLOT     = CLK_FREQ / SCAN_HZ;
  localparam int unsigned CntW     = $clog2(SLOT);
  localparam int unsigned IdxW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DutyStep = SLOT / 8;

  logic [CntW-1:0]         slot_cnt_q;
  logic [IdxW-1:0]         idx_q;
  logic [2:0]              bright_q;
  logic                    first_q;
  logic [DIGITS-1:0][3:0]  val_q;
  logic [DIGITS-1:0]       en_q;
  logic [DIGITS-1:0]       dp_q;
  logic [DIGITS-1:0]       seg_sel_q;
  logic [7:0]              seg_data_q;

  logic                    slot_wrap;
  logic                    frame_wrap;
  logic                    load_shadow;
  logic                    in_duty;
  logic                    blank;
  logic                    lit;
  logic [6:0]              seg_hex;
  logic [7:0]              seg_data_d;
  logic [DIGITS-1:0]       seg_sel_d;

  always_comb begin
    slot_wrap   = (slot_cnt_q == CntW'(SLOT - 1));
    frame_wrap  = slot_wrap && (idx_q == IdxW'(DIGITS - 1));
    // Shadows also load on the first post-reset cycle so the first frame is not blank data
    load_shadow = frame_wrap || first_q;
    in_duty     = (32'(slot_cnt_q) < (32'(bright_q) + 32'd1) * DutyStep);
  end

`ifdef SEG_BLINK_EN
  localparam int unsigned HALF   = CLK_FREQ / (2 * BLINK_HZ);
  localparam int unsigned BlinkW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [BlinkW-1:0] blink_cnt_q;
  logic              blink_on_q;
  logic [DIGITS-1:0] blink_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      blink_q     <= '0;
    end else begin
      if (blink_cnt_q == BlinkW'(HALF - 1)) begin
        blink_cnt_q <= '0;
        blink_on_q  <= ~blink_on_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BlinkW'(1);
      end
      if (load_shadow) begin
        blink_q <= blink;
      end
    end
  end

  assign blank = blink_q[idx_q] && !blink_on_q;
`else
  logic unused_blink;
  assign unused_blink = ^blink ^ BLINK_HZ[0];
  assign blank        = 1'b0;
`endif

  seg_hex_decoder u_hex (
    .value_i (val_q[idx_q]),
    .seg_o   (seg_hex)
  );

  always_comb begin
    lit        = en_q[idx_q] && in_duty && !blank;
    seg_data_d = SEG_DARK;
    if (lit) begin
      seg_data_d[SEG_G:SEG_A] = seg_hex;
      seg_data_d[SEG_DP]      = dp_q[idx_q];
    end
    for (int unsigned i = 0; i < DIGITS; i++) begin
      seg_sel_d[i] = !(lit && (idx_q == IdxW'(i)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q <= '0;
      idx_q      <= '0;
      bright_q   <= '0;
      first_q    <= 1'b1;
      val_q      <= '0;
      en_q       <= '0;
      dp_q       <= '0;
      seg_sel_q  <= '1;
      seg_data_q <= SEG_DARK;
    end else begin
      slot_cnt_q <= slot_wrap ? '0 : slot_cnt_q + CntW'(1);
      if (slot_wrap) begin
        idx_q <= (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
      end
      // Slot 0 is always inside the duty window, so the stale level there is harmless
      if (slot_cnt_q == '0) begin
        bright_q <= brightness;
      end
      first_q <= 1'b0;
      if (load_shadow) begin
        val_q <= digits;
        en_q  <= digit_en;
        dp_q  <= dp;
      end
      seg_sel_q  <= seg_sel_d;
      seg_data_q <= seg_data_d;
    end
  end

  assign seg_sel  = seg_sel_q;
  assign seg_data = seg_data_q;

endmodule

// File: tb/tb_led_seg_scanner_n.sv
// Self-checking bench for led_seg_scanner_n: time-indexed reference model plus pinned literals.
module tb_led_seg_scanner_n;

  localparam int D    = 4;
  localparam int SLOT = 16;
`ifdef SEG_BLINK_EN
  localparam int HALF = 80;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  digit_en;
  logic [3:0]  dp;
  logic [3:0]  blink;
  logic [2:0]  brightness;
  logic [7:0]  seg_data;
  logic [3:0]  seg_sel;

  always #5 clk = ~clk;

  led_seg_scanner_n #(
    .DIGITS   (4),
    .CLK_FREQ (1600),
    .SCAN_HZ  (100),
    .BLINK_HZ (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .digit_en   (digit_en),
    .dp         (dp),
    .blink      (blink),
    .brightness (brightness),
    .seg_data   (seg_data),
    .seg_sel    (seg_sel)
  );

  logic [6:0] hex_tab [16];
  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: t counts clock edges since reset release
  int          t = 0;
  bit          m_ready = 0;
  bit          m_sh = 0;
  logic [15:0] m_dig;
  logic [3:0]  m_en;
  logic [3:0]  m_dp;
`ifdef SEG_BLINK_EN
  logic [3:0]  m_blink;
`endif
  int          m_br = 0;
  logic [3:0]  exp_sel;
  logic [7:0]  exp_data;

  initial begin
    hex_tab[0]  = 7'h3F; hex_tab[1]  = 7'h06; hex_tab[2]  = 7'h5B; hex_tab[3]  = 7'h4F;
    hex_tab[4]  = 7'h66; hex_tab[5]  = 7'h6D; hex_tab[6]  = 7'h7D; hex_tab[7]  = 7'h07;
    hex_tab[8]  = 7'h7F; hex_tab[9]  = 7'h6F; hex_tab[10] = 7'h77; hex_tab[11] = 7'h7C;
    hex_tab[12] = 7'h39; hex_tab[13] = 7'h5E; hex_tab[14] = 7'h79; hex_tab[15] = 7'h71;
  end

  // Model: output after each edge is a function of the time-derived scan position before it
  initial begin
    forever begin
      int sc;
      int ix;
      bit lit;
      @(posedge clk);
      if (rst) begin
        t        = 0;
        m_sh     = 0;
        m_br     = 0;
        exp_sel  = 4'hF;
        exp_data = 8'h00;
        m_ready  = 1;
      end else begin
        sc  = t % SLOT;
        ix  = (t / SLOT) % D;
        lit = m_sh && m_en[ix] && (sc < (m_br + 1) * SLOT / 8);
`ifdef SEG_BLINK_EN
        if (m_blink[ix] && (((t / HALF) % 2) == 1)) lit = 0;
`endif
        exp_sel  = 4'hF;
        exp_data = 8'h00;
        if (lit) begin
          exp_sel[ix] = 1'b0;
          exp_data    = {m_dp[ix], hex_tab[m_dig[ix*4 +: 4]]};
        end
        if (sc == 0) m_br = int'(brightness);
        if (t == 0 || (sc == SLOT - 1 && ix == D - 1)) begin
          m_dig = digits;
          m_en  = digit_en;
          m_dp  = dp;
`ifdef SEG_BLINK_EN
          m_blink = blink;
`endif
          m_sh  = 1;
        end
        t++;
      end
    end
  end

  // Every-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (m_ready) begin
        n_cmp++;
        if (seg_sel !== exp_sel || seg_data !== exp_data) begin
          n_fail++;
          $display("FAIL model_cycle t=%0d: got sel=%b data=%h, expected sel=%b data=%h",
                   t, seg_sel, seg_data, exp_sel, exp_data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] s, input logic [7:0] d);
    n_cmp++;
    if (seg_sel !== s || seg_data !== d) begin
      n_fail++;
      $display("FAIL %s: got sel=%b data=%h, expected sel=%b data=%h",
               name, seg_sel, seg_data, s, d);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Stop at the negedge where outputs show scan state n (edge count t == n+1)
  task automatic goto_state(input int n);
    int guard = 0;
    @(negedge clk);
    while (t != n + 1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL goto_state_timeout: got t=%0d, expected %0d", t, n + 1);
    end
  endtask

  initial begin
    int cnt;
    int d1;
    int s3;
    rst        = 1'b1;
    digits     = 16'hFA80;
    digit_en   = 4'hF;
    dp         = 4'h0;
    blink      = 4'h0;
    brightness = 3'd7;

    repeat (3) begin
      @(negedge clk);
      chk("reset_dark", 4'b1111, 8'h00);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_dark", 4'b1111, 8'h00);

    // Basic scan, full brightness
    goto_state(69);  chk("scan_d0", 4'b1110, 8'h3F);
    goto_state(85);  chk("scan_d1", 4'b1101, 8'h7F);
    goto_state(101); chk("scan_d2", 4'b1011, 8'h77);
    goto_state(117); chk("scan_d3", 4'b0111, 8'h71);

    // Brightness change mid-slot takes effect from next slot only
    goto_state(130);
    brightness = 3'd1;
    goto_state(133); chk("pwm_old_level", 4'b1110, 8'h3F);
    goto_state(160);
    cnt = (seg_sel != 4'hF) ? 1 : 0;
    for (int i = 1; i < SLOT; i++) begin
      @(negedge clk);
      if (seg_sel != 4'hF) cnt++;
      if (i == 3) chk("pwm_lit", 4'b1011, 8'h77);
      if (i == 6) chk("pwm_dark", 4'b1111, 8'h00);
    end
    chk_int("pwm_on_cycles", cnt, 4);

    // Shadow coherence: change while digit 2 is scanning
    goto_state(226);
    digits = 16'h1234;
    goto_state(227); chk("shadow_d2_old", 4'b1011, 8'h77);
    goto_state(242); chk("shadow_d3_old", 4'b0111, 8'h71);
    goto_state(258); chk("shadow_d0_new", 4'b1110, 8'h66);

    // Blink, enable and decimal point
    goto_state(300);
    brightness = 3'd7;
    blink      = 4'b0010;
    digit_en   = 4'b0111;
    dp         = 4'b0001;
    digits     = 16'h1230;
    goto_state(325); chk("dp_digit0", 4'b1110, 8'hBF);
    d1 = 0;
    s3 = 0;
    for (int i = 0; i < 640; i++) begin
      @(negedge clk);
      if (seg_sel == 4'b1101) d1++;
      if (seg_sel[3] == 1'b0) s3++;
    end
`ifdef SEG_BLINK_EN
    chk_int("blink_d1_lit_cycles", d1, 64);
`else
    chk_int("blink_d1_lit_cycles", d1, 160);
`endif
    chk_int("digit3_disabled", s3, 0);

    // Reset in mid-frame
    goto_state(1005);
    rst = 1'b1;
    @(negedge clk);
    chk("midframe_reset_dark", 4'b1111, 8'h00);
    rst = 1'b0;
    goto_state(5);  chk("restart_d0", 4'b1110, 8'hBF);
    goto_state(17); chk("restart_d1", 4'b1101, 8'h4F);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(299) == 0) rst = 1'b1;
      if ($urandom_range(19) == 0) begin
        digits     = 16'($urandom);
        digit_en   = 4'($urandom);
        dp         = 4'($urandom);
        blink      = 4'($urandom);
        brightness = 3'($urandom);
      end
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
